// File: rtl/reg_context_engine.sv
// reg_context_engine
// Register-file context save/restore master. On a save request it walks the
// register read port over every register and streams each value to memory;
// on a restore request it reads each word back from memory and writes it into
// the register file. busy stalls the core for the whole operation, and done
// pulses for one cycle at the end.
module reg_context_engine #(
  parameter int NUM_REGS   = 8,
  parameter int REG_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int SKIP_R0    = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start_save,
  input  logic                        start_restore,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_REGS)-1:0] rf_rs,
  input  logic [REG_WIDTH-1:0]        rf_rs_val,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd,
  output logic [REG_WIDTH-1:0]        rf_reg_in,
  output logic                        rf_write_en,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [REG_WIDTH-1:0]        mem_wdata,
  input  logic                        mem_ack,
  input  logic [REG_WIDTH-1:0]        mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
  // With SKIP_R0 the hard-wired zero register is never touched.
  localparam logic [IDX_W-1:0] IDX_FIRST = (SKIP_R0 != 0) ? IDX_W'(1) : '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    RD_REQ = 3'd2,
    RD_WR  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [REG_WIDTH-1:0]    rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   walk_addr;

  // Memory address of the current register; wraps modulo 2^ADDR_WIDTH.
  assign walk_addr = base_q + ADDR_WIDTH'(idx_q);

  // Control state: FSM state and walk index, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath holding registers; only observed through state-gated outputs.
  always_ff @(posedge CLK) begin
    base_q  <= base_d;
    rdata_q <= rdata_d;
  end

  // Next-state logic: accept requests in IDLE, advance the walk on each ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        // Save has priority; a simultaneous restore request is dropped.
        if (start_save) begin
          state_d = SAVE;
          base_d  = base_addr;
          idx_d   = IDX_FIRST;
        end else if (start_restore) begin
          state_d = RD_REQ;
          base_d  = base_addr;
          idx_d   = IDX_FIRST;
        end
      end
      SAVE: begin
        if (mem_ack) begin
          if (idx_q == IDX_LAST) state_d = DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = RD_WR;
        end
      end
      RD_WR: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: every port is idle-zero outside the state that uses it.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    rf_rs       = '0;
    rf_rd       = '0;
    rf_reg_in   = '0;
    rf_write_en = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state_q)
      IDLE: ;
      SAVE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        rf_rs     = idx_q;
        mem_addr  = walk_addr;
        mem_wdata = rf_rs_val;
      end
      RD_REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = walk_addr;
      end
      RD_WR: begin
        busy        = 1'b1;
        rf_write_en = 1'b1;
        rf_rd       = idx_q;
        rf_reg_in   = rdata_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_context_engine.sv
// Testbench for reg_context_engine: a register-file model and a word memory
// with programmable ack latency sit around two instances (SKIP_R0=0 and 1).
// Expected memory/register-file transactions are queued by the stimulus and
// popped by an independent monitor that runs on the falling edge.
module tb_reg_context_engine;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int AW = 16;

  localparam int K_WR   = 0;  // memory write accepted
  localparam int K_RA   = 1;  // memory read accepted
  localparam int K_RF   = 2;  // register-file write
  localparam int K_DONE = 3;  // done pulse

  typedef struct {
    int         inst;
    int         kind;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  busy_cyc[2];
  int  done_cyc[2];
  int  rfw_cyc[2];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ss, sr, ss2, sr2;
  logic [AW-1:0] base, base2;

  // Instance 0 (SKIP_R0 = 0)
  logic          busy, done, rf_write_en, mem_req, mem_we, mem_ack;
  logic [2:0]    rf_rs, rf_rd;
  logic [W-1:0]  rf_rs_val, rf_reg_in, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  // Instance 1 (SKIP_R0 = 1)
  logic          busy2, done2, rf_write_en2, mem_req2, mem_we2, mem_ack2;
  logic [2:0]    rf_rs2, rf_rd2;
  logic [W-1:0]  rf_rs_val2, rf_reg_in2, mem_wdata2, mem_rdata2;
  logic [AW-1:0] mem_addr2;

  reg_context_engine #(.NUM_REGS(N), .REG_WIDTH(W), .ADDR_WIDTH(AW), .SKIP_R0(0)) dut (
    .CLK(clk), .RST(rst), .start_save(ss), .start_restore(sr), .base_addr(base),
    .busy(busy), .done(done), .rf_rs(rf_rs), .rf_rs_val(rf_rs_val), .rf_rd(rf_rd),
    .rf_reg_in(rf_reg_in), .rf_write_en(rf_write_en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  reg_context_engine #(.NUM_REGS(N), .REG_WIDTH(W), .ADDR_WIDTH(AW), .SKIP_R0(1)) dut2 (
    .CLK(clk), .RST(rst), .start_save(ss2), .start_restore(sr2), .base_addr(base2),
    .busy(busy2), .done(done2), .rf_rs(rf_rs2), .rf_rs_val(rf_rs_val2), .rf_rd(rf_rd2),
    .rf_reg_in(rf_reg_in2), .rf_write_en(rf_write_en2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2)
  );

  // Register-file and memory models
  logic [W-1:0] rf0 [0:N-1];
  logic [W-1:0] rf2 [0:N-1];
  logic [W-1:0] mem0 [0:65535];
  logic [W-1:0] mem2 [0:65535];
  logic         pl_en = 1'b0;
  int           pl_tgt = 0;
  logic [15:0]  pl_addr = '0;
  logic [15:0]  pl_data = '0;
  int           ack_delay = 0;
  int           wait_cnt = 0;

  assign rf_rs_val  = rf0[rf_rs];
  assign rf_rs_val2 = rf2[rf_rs2];
  assign mem_rdata  = mem0[mem_addr];
  assign mem_rdata2 = mem2[mem_addr2];
  assign mem_ack    = mem_req && (wait_cnt == ack_delay);
  assign mem_ack2   = mem_req2;

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack)     mem0[mem_addr]  <= mem_wdata;
    if (rf_write_en)                      rf0[rf_rd]      <= rf_reg_in;
    if (mem_req2 && mem_we2 && mem_ack2)  mem2[mem_addr2] <= mem_wdata2;
    if (rf_write_en2)                     rf2[rf_rd2]     <= rf_reg_in2;
    if (pl_en) begin
      case (pl_tgt)
        0:       rf0[pl_addr[2:0]] <= pl_data;
        1:       mem0[pl_addr]     <= pl_data;
        2:       rf2[pl_addr[2:0]] <= pl_data;
        default: mem2[pl_addr]     <= pl_data;
      endcase
    end
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push(input int inst, input int kind, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.inst = inst; e.kind = kind; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input int inst, input int kind, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got inst%0d kind%0d addr %h data %h, required none",
               inst, kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.a !== a || e.d !== d) begin
        n_bad++;
        $display("FAIL event: got inst%0d kind%0d addr %h data %h, required inst%0d kind%0d addr %h data %h",
                 inst, kind, a, d, e.inst, e.kind, e.a, e.d);
      end
    end
  endtask

  task automatic mon_inst(input int inst, input logic req, input logic we, input logic ack,
                          input logic [15:0] addr, input logic [15:0] wd, input logic wen,
                          input logic [2:0] rd, input logic [15:0] rin, input logic dn,
                          input logic bsy);
    if (req && we && ack)  mon_ev(inst, K_WR, addr, wd);
    if (req && !we && ack) mon_ev(inst, K_RA, addr, 16'h0000);
    if (wen)               mon_ev(inst, K_RF, {13'd0, rd}, rin);
    if (dn)                mon_ev(inst, K_DONE, 16'h0000, 16'h0000);
    if (bsy) busy_cyc[inst]++;
    if (dn)  done_cyc[inst]++;
    if (wen) rfw_cyc[inst]++;
  endtask

  // Monitor: observes both instances on the falling edge
  initial begin
    logic        hold;
    logic [15:0] h_addr, h_wd;
    logic        h_we;
    hold = 1'b0; h_addr = '0; h_wd = '0; h_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy_cyc[i] = 0; done_cyc[i] = 0; rfw_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      mon_inst(0, mem_req, mem_we, mem_ack, mem_addr, mem_wdata, rf_write_en, rf_rd,
               rf_reg_in, done, busy);
      mon_inst(1, mem_req2, mem_we2, mem_ack2, mem_addr2, mem_wdata2, rf_write_en2, rf_rd2,
               rf_reg_in2, done2, busy2);
      if (hold && mem_req)
        chk("hold_stable", {31'd0, mem_we, mem_addr, mem_wd_pad(mem_wdata)},
                           {31'd0, h_we, h_addr, mem_wd_pad(h_wd)});
      hold   = mem_req && !mem_ack;
      h_addr = mem_addr;
      h_we   = mem_we;
      h_wd   = mem_wdata;
    end
  end

  function automatic logic [15:0] mem_wd_pad(input logic [15:0] v);
    return v;
  endfunction

  task automatic pl(input int tgt, input logic [15:0] a, input logic [15:0] d);
    pl_tgt = tgt; pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic start(input int inst, input logic sv, input logic rs, input logic [15:0] b);
    if (inst == 0) begin ss = sv; sr = rs; base = b; end
    else           begin ss2 = sv; sr2 = rs; base2 = b; end
    @(posedge clk); #1;
    ss = 1'b0; sr = 1'b0; ss2 = 1'b0; sr2 = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int max, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (((inst == 0) ? busy : busy2) == 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, max);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int b0, d0, w0, b1, d1, w1;
    logic [15:0] wrap_tbl [0:7];
    bit found;
    wrap_tbl[0] = 16'hFFFE; wrap_tbl[1] = 16'hFFFF; wrap_tbl[2] = 16'h0000; wrap_tbl[3] = 16'h0001;
    wrap_tbl[4] = 16'h0002; wrap_tbl[5] = 16'h0003; wrap_tbl[6] = 16'h0004; wrap_tbl[7] = 16'h0005;
    rst = 1'b1; ss = 1'b0; sr = 1'b0; ss2 = 1'b0; sr2 = 1'b0; base = '0; base2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_ctrl", {59'd0, busy, done, mem_req, mem_we, rf_write_en}, 64'd0);
    chk("reset_bus", {32'd0, mem_addr, mem_wdata}, 64'd0);
    chk("reset_idx", {42'd0, rf_rs, rf_rd, rf_reg_in}, 64'd0);
    chk("reset_ctrl2", {62'd0, busy2, mem_req2}, 64'd0);
    @(posedge clk); #1;

    // 1: save r_i = 0x1000+i to 0x0200, ack tied high
    for (int i = 0; i < N; i++) pl(0, 16'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < N; i++) push(0, K_WR, 16'h0200 + 16'(i), 16'h1000 + 16'(i));
    push(0, K_DONE, 16'h0, 16'h0);
    b0 = busy_cyc[0]; d0 = done_cyc[0]; w0 = rfw_cyc[0];
    start(0, 1'b1, 1'b0, 16'h0200);
    wait_idle(0, 40, "save");
    chk("save_busy_cycles", 64'(busy_cyc[0] - b0), 64'd9);
    chk("save_done_pulses", 64'(done_cyc[0] - d0), 64'd1);
    chk("save_no_rf_write", 64'(rfw_cyc[0] - w0), 64'd0);
    for (int i = 0; i < N; i++) chk("save_image", 64'(mem0[16'h0200 + 16'(i)]), 64'(16'h1000 + 16'(i)));
    chk("save_queue_drained", 64'(exp_q.size()), 64'd0);

    // 2: restore from 0x0300, mem = 0xA0+i
    for (int i = 0; i < N; i++) pl(1, 16'h0300 + 16'(i), 16'h00A0 + 16'(i));
    for (int i = 0; i < N; i++) begin
      push(0, K_RA, 16'h0300 + 16'(i), 16'h0);
      push(0, K_RF, 16'(i), 16'h00A0 + 16'(i));
    end
    push(0, K_DONE, 16'h0, 16'h0);
    b0 = busy_cyc[0]; w0 = rfw_cyc[0];
    start(0, 1'b0, 1'b1, 16'h0300);
    wait_idle(0, 60, "restore");
    chk("restore_busy_cycles", 64'(busy_cyc[0] - b0), 64'd17);
    chk("restore_rf_writes", 64'(rfw_cyc[0] - w0), 64'd8);
    for (int i = 0; i < N; i++) chk("restore_rf", 64'(rf0[i]), 64'(16'h00A0 + 16'(i)));
    chk("restore_queue_drained", 64'(exp_q.size()), 64'd0);

    // 3: save again with three wait cycles per request
    for (int i = 0; i < N; i++) pl(0, 16'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < N; i++) pl(1, 16'h0200 + 16'(i), 16'h0000);
    ack_delay = 3;
    for (int i = 0; i < N; i++) push(0, K_WR, 16'h0200 + 16'(i), 16'h1000 + 16'(i));
    push(0, K_DONE, 16'h0, 16'h0);
    b0 = busy_cyc[0];
    start(0, 1'b1, 1'b0, 16'h0200);
    wait_idle(0, 120, "bp_save");
    ack_delay = 0;
    chk("bp_busy_cycles", 64'(busy_cyc[0] - b0), 64'd33);
    for (int i = 0; i < N; i++) chk("bp_image", 64'(mem0[16'h0200 + 16'(i)]), 64'(16'h1000 + 16'(i)));
    chk("bp_queue_drained", 64'(exp_q.size()), 64'd0);

    // 4: simultaneous starts, then starts while in SAVE and in DONE
    for (int i = 0; i < N; i++) push(0, K_WR, 16'h0240 + 16'(i), 16'h1000 + 16'(i));
    push(0, K_DONE, 16'h0, 16'h0);
    b0 = busy_cyc[0]; d0 = done_cyc[0]; w0 = rfw_cyc[0];
    start(0, 1'b1, 1'b1, 16'h0240);
    start(0, 1'b0, 1'b1, 16'h0300);
    start(0, 1'b1, 1'b0, 16'h0280);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; break; end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL prio_done_timeout: got no done, required one done pulse");
    end
    ss = 1'b1; base = 16'h02C0;
    @(posedge clk); #1;
    ss = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("prio_busy_cycles", 64'(busy_cyc[0] - b0), 64'd9);
    chk("prio_done_pulses", 64'(done_cyc[0] - d0), 64'd1);
    chk("prio_no_restore", 64'(rfw_cyc[0] - w0), 64'd0);
    chk("prio_idle_after", {63'd0, busy}, 64'd0);
    chk("prio_queue_drained", 64'(exp_q.size()), 64'd0);

    // 5a: address wrap from base 0xFFFE
    for (int i = 0; i < N; i++) push(0, K_WR, wrap_tbl[i], 16'h1000 + 16'(i));
    push(0, K_DONE, 16'h0, 16'h0);
    start(0, 1'b1, 1'b0, 16'hFFFE);
    wait_idle(0, 40, "wrap_save");
    chk("wrap_ffff", 64'(mem0[16'hFFFF]), 64'h1001);
    chk("wrap_0000", 64'(mem0[16'h0000]), 64'h1002);
    chk("wrap_0005", 64'(mem0[16'h0005]), 64'h1007);

    // 5b: SKIP_R0 instance, save then restore
    for (int i = 0; i < N; i++) pl(2, 16'(i), 16'h2000 + 16'(i));
    pl(3, 16'h0400, 16'hDEAD);
    for (int i = 1; i < N; i++) push(1, K_WR, 16'h0400 + 16'(i), 16'h2000 + 16'(i));
    push(1, K_DONE, 16'h0, 16'h0);
    b1 = busy_cyc[1]; d1 = done_cyc[1];
    start(1, 1'b1, 1'b0, 16'h0400);
    wait_idle(1, 40, "skip_save");
    chk("skip_save_busy", 64'(busy_cyc[1] - b1), 64'd8);
    chk("skip_save_done", 64'(done_cyc[1] - d1), 64'd1);
    chk("skip_base_untouched", 64'(mem2[16'h0400]), 64'hDEAD);
    for (int i = 0; i < N; i++) pl(3, 16'h0500 + 16'(i), 16'h00B0 + 16'(i));
    for (int i = 1; i < N; i++) begin
      push(1, K_RA, 16'h0500 + 16'(i), 16'h0);
      push(1, K_RF, 16'(i), 16'h00B0 + 16'(i));
    end
    push(1, K_DONE, 16'h0, 16'h0);
    w1 = rfw_cyc[1];
    start(1, 1'b0, 1'b1, 16'h0500);
    wait_idle(1, 60, "skip_restore");
    chk("skip_rf_writes", 64'(rfw_cyc[1] - w1), 64'd7);
    chk("skip_r0_kept", 64'(rf2[0]), 64'h2000);
    for (int i = 1; i < N; i++) chk("skip_restore_rf", 64'(rf2[i]), 64'(16'h00B0 + 16'(i)));
    chk("skip_queue_drained", 64'(exp_q.size()), 64'd0);

    // 6: reset during the third restore write
    for (int i = 0; i < N; i++) pl(0, 16'(i), 16'h5500 + 16'(i));
    for (int i = 0; i < 3; i++) begin
      push(0, K_RA, 16'h0300 + 16'(i), 16'h0);
      push(0, K_RF, 16'(i), 16'h00A0 + 16'(i));
    end
    start(0, 1'b0, 1'b1, 16'h0300);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rf_write_en && rf_rd == 3'd2) begin found = 1'b1; break; end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL abort_trigger_timeout: got no write to r2, required one");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {61'd0, busy, rf_write_en, mem_req}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("abort_rf_updated", 64'(rf0[i]), 64'(16'h00A0 + 16'(i)));
    for (int i = 3; i < N; i++) chk("abort_rf_kept", 64'(rf0[i]), 64'(16'h5500 + 16'(i)));
    chk("abort_queue_drained", 64'(exp_q.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
